// File: rtl/mem_stage_if.sv
// Data-memory request/response bundle between the MEM stage and data memory.
// The stage side is the master; the memory side is the slave.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr,
        output dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr,
        input  dmem_be, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores, aligns lanes, formats
// load data, stalls upstream while busy and squashes bad or lost accesses.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_MEM_in,
    input  logic [31:0] rs2_data_MEM_in,
    input  logic        MemRead_MEM_in,
    input  logic        MemWrite_MEM_in,
    input  logic [2:0]  funct3_MEM_in,
    input  logic        RegWrite_MEM_in,
    input  logic        MemtoReg_MEM_in,
    input  logic [4:0]  rd_MEM_in,
    mem_stage_if.master dmem,
    output logic [31:0] mem_data_MEM_out,
    output logic [31:0] alu_MEM_out,
    output logic        MemtoReg_MEM_out,
    output logic [4:0]  rd_MEM_out,
    output logic        RegWrite_MEM_out,
    output logic        stall_out,
    output logic        mem_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        tmo_q;

    logic        is_ld, is_st, is_mem;
    logic        f3_ok, align_ok, legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign is_ld  = MemRead_MEM_in & ~MemWrite_MEM_in;
    assign is_st  = MemWrite_MEM_in & ~MemRead_MEM_in;
    assign is_mem = MemRead_MEM_in | MemWrite_MEM_in;
    assign legal  = f3_ok & align_ok;

    always_comb begin
        f3_ok = 1'b0;
        if (is_ld)
            f3_ok = funct3_MEM_in inside
                {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_st)
            f3_ok = funct3_MEM_in inside {3'b000, 3'b001, 3'b010};
        case (funct3_MEM_in[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~alu_MEM_in[0];
            2'b10:   align_ok = (alu_MEM_in[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    // Loads read the whole word; stores replicate data across lanes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        if (is_st) begin
            case (funct3_MEM_in[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << alu_MEM_in[1:0];
                    st_wdata = {4{rs2_data_MEM_in[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << alu_MEM_in[1:0];
                    st_wdata = {2{rs2_data_MEM_in[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = rs2_data_MEM_in;
                end
            endcase
        end
    end

    assign alu_MEM_out      = alu_MEM_in;
    assign MemtoReg_MEM_out = MemtoReg_MEM_in;
    assign rd_MEM_out       = rd_MEM_in;
    assign dmem.dmem_addr   = {alu_MEM_in[31:2], 2'b00};

    always_comb begin
        dmem.dmem_req    = 1'b0;
        dmem.dmem_we     = 1'b0;
        dmem.dmem_be     = 4'd0;
        dmem.dmem_wdata  = 32'd0;
        stall_out        = 1'b0;
        mem_exc          = 1'b0;
        bus_err          = 1'b0;
        mem_data_MEM_out = 32'd0;
        RegWrite_MEM_out = RegWrite_MEM_in & ~rst;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (is_mem && !legal) begin
                        mem_exc          = 1'b1;
                        RegWrite_MEM_out = 1'b0;
                    end else if (is_mem) begin
                        dmem.dmem_req   = 1'b1;
                        dmem.dmem_we    = is_st;
                        dmem.dmem_be    = st_be;
                        dmem.dmem_wdata = st_wdata;
                        stall_out       = 1'b1;
                    end
                end
                WAIT: stall_out = 1'b1;
                DONE: begin
                    mem_data_MEM_out = rdata_q;
                    if (tmo_q) begin
                        bus_err          = 1'b1;
                        RegWrite_MEM_out = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Responses seen in IDLE or DONE are stale and simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            rdata_q <= 32'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            tmo_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_mem && legal && dmem.dmem_ready) begin
                        off_q   <= alu_MEM_in[1:0];
                        f3_q    <= funct3_MEM_in;
                        rdata_q <= 32'd0;
                        cnt_q   <= 16'd0;
                        tmo_q   <= 1'b0;
                        state_q <= is_st ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rvalid) begin
                        rdata_q <= fmt_load(dmem.dmem_rdata, off_q, f3_q);
                        state_q <= DONE;
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    tmo_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a byte-level
// reference model of RV32I load/store behaviour.
module tb_mem_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] alu_in, rs2_in;
    logic        mr, mw, rw_in, mtr_in;
    logic [2:0]  f3_in;
    logic [4:0]  rd_in;
    logic [31:0] mdata, alu_out;
    logic        mtr_out, rw_out, stall, exc, berr;
    logic [4:0]  rd_out;
    int checks = 0;
    int errors = 0;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .alu_MEM_in(alu_in), .rs2_data_MEM_in(rs2_in),
        .MemRead_MEM_in(mr), .MemWrite_MEM_in(mw),
        .funct3_MEM_in(f3_in), .RegWrite_MEM_in(rw_in),
        .MemtoReg_MEM_in(mtr_in), .rd_MEM_in(rd_in),
        .dmem(bus),
        .mem_data_MEM_out(mdata), .alu_MEM_out(alu_out),
        .MemtoReg_MEM_out(mtr_out), .rd_MEM_out(rd_out),
        .RegWrite_MEM_out(rw_out), .stall_out(stall),
        .mem_exc(exc), .bus_err(berr)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit exp_legal(bit ld, bit st, logic [2:0] f3,
                                     logic [31:0] a);
        bit ok;
        if (ld == st) return 0;
        if (ld) ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    ok = (f3 == 0 || f3 == 1 || f3 == 2);
        return ok && ((a % size_of(f3)) == 0);
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] w, int off,
                                             logic [2:0] f3);
        longint b, h;
        b = longint'(w >> (8 * off)) % 256;
        h = longint'(w >> (8 * off)) % 65536;
        case (f3)
            3'd0: return 32'(b >= 128 ? b - 256 : b);
            3'd1: return 32'(h >= 32768 ? h - 65536 : h);
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(logic [2:0] f3, int off);
        return 4'(((1 << size_of(f3)) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wd(logic [2:0] f3, logic [31:0] d);
        case (size_of(f3))
            1: return (d % 256) * 32'h01010101;
            2: return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_nop();
        mr = 0; mw = 0; rw_in = 1; mtr_in = 0;
        f3_in = 0; rd_in = 5'd1; alu_in = $urandom; rs2_in = $urandom;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] word, input int rdy_dly,
                            input int rv_at, output logic [31:0] data,
                            output int waits, output logic be_err,
                            output logic rw, output bit ok);
        ok = 1; waits = 0; data = 0; be_err = 0; rw = 0;
        @(negedge clk);
        alu_in = a; f3_in = f3; mr = 1; mw = 0;
        rw_in = 1; mtr_in = 1; rd_in = 5'd7;
        for (int k = 0; k <= rdy_dly; k++) begin
            bus.dmem_ready  = (k == rdy_dly);
            bus.dmem_rvalid = (k == rdy_dly);
            bus.dmem_rdata  = 32'hDEADBEEF;
            #1;
            if (!bus.dmem_req || !stall) ok = 0;
            if (k < rdy_dly) @(negedge clk);
        end
        @(negedge clk);
        bus.dmem_ready = 0;
        for (int c = 0; c < 64; c++) begin
            bus.dmem_rvalid = (c == rv_at);
            bus.dmem_rdata  = (c == rv_at) ? word : $urandom;
            #1;
            if (!stall) begin
                data = mdata; be_err = berr; rw = rw_out;
                break;
            end
            waits++;
            if (c == 63) ok = 0;
            @(negedge clk);
        end
        bus.dmem_rvalid = 0;
    endtask

    task automatic run_store(input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] d, input int rdy_dly,
                             output logic [3:0] be, output logic [31:0] wd,
                             output logic [31:0] ad, output logic we,
                             output int stalls, output bit ok);
        ok = 1; stalls = 0;
        @(negedge clk);
        alu_in = a; f3_in = f3; mr = 0; mw = 1; rs2_in = d;
        rw_in = 0; mtr_in = 0;
        for (int k = 0; k <= rdy_dly; k++) begin
            bus.dmem_ready = (k == rdy_dly);
            #1;
            if (!bus.dmem_req) ok = 0;
            if (k == 0) begin
                be = bus.dmem_be; wd = bus.dmem_wdata;
                ad = bus.dmem_addr; we = bus.dmem_we;
            end else if (be !== bus.dmem_be || wd !== bus.dmem_wdata) begin
                ok = 0;
            end
            if (stall) stalls++;
            if (k < rdy_dly) @(negedge clk);
        end
        @(negedge clk);
        bus.dmem_ready = 0;
        #1;
        if (stall || bus.dmem_req || mdata !== 0) ok = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1; mr = 1; mw = 0; f3_in = 3'd2;
        alu_in = 32'h100; rw_in = 1; rd_in = 5'd9;
        #1;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, stall, exc, berr, rw_out} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000",
                {bus.dmem_req, bus.dmem_we, stall, exc, berr, rw_out});
        end
        checks++;
        if (mdata !== 0 || bus.dmem_be !== 0 || bus.dmem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0",
                mdata, bus.dmem_be, bus.dmem_wdata);
        end
        checks++;
        if (alu_out !== 32'h100 || rd_out !== 5'd9) begin
            errors++;
            $display("FAIL reset_pass got %h/%0d exp 100/9", alu_out, rd_out);
        end
        @(negedge clk);
        rst = 0;
        set_nop();
    endtask

    task automatic test_nonmem();
        @(negedge clk);
        set_nop();
        alu_in = 32'h1234; rd_in = 5'd3; mtr_in = 1;
        #1;
        checks++;
        if (stall !== 0 || bus.dmem_req !== 0 || mdata !== 0) begin
            errors++;
            $display("FAIL nonmem_ctrl got s%b r%b d%h exp 0",
                stall, bus.dmem_req, mdata);
        end
        checks++;
        if (alu_out !== 32'h1234 || rw_out !== 1 || rd_out !== 3
            || mtr_out !== 1) begin
            errors++;
            $display("FAIL nonmem_pass got %h %b %0d %b exp 1234 1 3 1",
                alu_out, rw_out, rd_out, mtr_out);
        end
    endtask

    task automatic test_sb();
        logic [3:0] be; logic [31:0] wd, ad; logic we;
        int stalls; bit ok;
        run_store(32'h1003, 3'd0, 32'hAABBCCDD, 1, be, wd, ad, we,
                  stalls, ok);
        checks++;
        if (be !== 4'b1000 || wd !== 32'hDDDDDDDD || ad !== 32'h1000
            || we !== 1) begin
            errors++;
            $display("FAIL sb_lanes got %b %h %h %b exp 1000 DDDDDDDD 1000 1",
                be, wd, ad, we);
        end
        checks++;
        if (stalls !== 2 || !ok) begin
            errors++;
            $display("FAIL sb_timing got stalls %0d ok %0b exp 2 1",
                stalls, ok);
        end
    endtask

    task automatic test_load_format();
        logic [31:0] d; int w; logic be_err, rw; bit ok;
        run_load(32'h2002, 3'd0, 32'h00800000, 0, 2, d, w, be_err, rw, ok);
        checks++;
        if (d !== 32'hFFFFFF80 || w !== 3 || !ok || rw !== 1) begin
            errors++;
            $display("FAIL lb got %h waits %0d exp FFFFFF80 3", d, w);
        end
        run_load(32'h2002, 3'd4, 32'h00800000, 0, 2, d, w, be_err, rw, ok);
        checks++;
        if (d !== 32'h00000080 || !ok) begin
            errors++;
            $display("FAIL lbu got %h exp 00000080", d);
        end
        run_load(32'h2002, 3'd1, 32'h80000000, 1, 0, d, w, be_err, rw, ok);
        checks++;
        if (d !== 32'hFFFF8000 || w !== 1 || !ok) begin
            errors++;
            $display("FAIL lh got %h waits %0d exp FFFF8000 1", d, w);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_nop();
            bus.dmem_ready = 1;
            if (i == 0) begin
                mr = 1; f3_in = 3'd2; alu_in = 32'h1002;
            end else begin
                mw = 1; f3_in = 3'd3; alu_in = 32'h1000;
            end
            #1;
            checks++;
            if ({exc, bus.dmem_req, rw_out, stall} !== 4'b1000) begin
                errors++;
                $display("FAIL illegal%0d got %b exp 1000", i,
                    {exc, bus.dmem_req, rw_out, stall});
            end
        end
        @(negedge clk);
        set_nop();
        bus.dmem_ready = 0;
        #1;
        checks++;
        if (exc !== 0) begin
            errors++;
            $display("FAIL exc_pulse got %b exp 0", exc);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; int w; logic be_err, rw; bit ok;
        run_load(32'h3000, 3'd2, 32'h0, 0, -1, d, w, be_err, rw, ok);
        checks++;
        if (w !== 4 || be_err !== 1 || rw !== 0 || !ok) begin
            errors++;
            $display("FAIL timeout got waits %0d err %b rw %b exp 4 1 0",
                w, be_err, rw);
        end
        @(negedge clk);
        set_nop();
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hFFFFFFFF;
        #1;
        checks++;
        if (mdata !== 0 || stall !== 0 || berr !== 0) begin
            errors++;
            $display("FAIL stale_rvalid got %h %b %b exp 0 0 0",
                mdata, stall, berr);
        end
        @(negedge clk);
        bus.dmem_rvalid = 0;
        #1;
        checks++;
        if (mdata !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL stale_after got %h %b exp 0 0", mdata, stall);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d, word; int w; logic be_err, rw; bit ok;
        @(negedge clk);
        mr = 1; mw = 0; f3_in = 3'd2; alu_in = 32'h2000; rw_in = 1;
        bus.dmem_ready = 1;
        @(negedge clk);
        bus.dmem_ready = 0;
        #1;
        checks++;
        if (stall !== 1) begin
            errors++;
            $display("FAIL wait_entry got stall %b exp 1", stall);
        end
        rst = 1;
        #1;
        checks++;
        if ({stall, bus.dmem_req, berr, rw_out} !== 4'b0 || mdata !== 0) begin
            errors++;
            $display("FAIL rst_wait got %b %h exp 0000 0",
                {stall, bus.dmem_req, berr, rw_out}, mdata);
        end
        @(negedge clk);
        rst = 0;
        set_nop();
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h12345678;
        #1;
        checks++;
        if (stall !== 0 || mdata !== 0 || berr !== 0 || rw_out !== 1) begin
            errors++;
            $display("FAIL rst_after got %b %h %b %b exp 0 0 0 1",
                stall, mdata, berr, rw_out);
        end
        word = $urandom;
        run_load(32'h2000, 3'd2, word, 0, 1, d, w, be_err, rw, ok);
        checks++;
        if (d !== word || w !== 2 || be_err !== 0 || rw !== 1 || !ok) begin
            errors++;
            $display("FAIL lw_after_rst got %h waits %0d exp %h 2", d, w, word);
        end
    endtask

    task automatic test_random();
        logic [2:0] ldf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [31:0] a, word, d, wd, ad;
        logic [3:0] be; logic we, be_err, rw;
        logic [2:0] f3; int kind, w, rv, rdy, stalls; bit ok, ld, st;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            rdy  = $urandom_range(0, 2);
            word = $urandom;
            if (kind == 0) begin
                f3 = ldf3[$urandom_range(0, 4)];
                a  = ($urandom & 32'hFFFFFFFC)
                     + size_of(f3) * $urandom_range(0, 4 / size_of(f3) - 1);
                rv = $urandom_range(0, 3);
                run_load(a, f3, word, rdy, rv, d, w, be_err, rw, ok);
                checks++;
                if (d !== exp_load(word, a % 4, f3) || w !== rv + 1
                    || be_err || !rw || !ok) begin
                    errors++;
                    $display("FAIL rnd_load f3 %0d a %h got %h w %0d exp %h w %0d",
                        f3, a, d, w, exp_load(word, a % 4, f3), rv + 1);
                end
            end else if (kind == 1) begin
                f3 = 3'($urandom_range(0, 2));
                a  = ($urandom & 32'hFFFFFFFC)
                     + size_of(f3) * $urandom_range(0, 4 / size_of(f3) - 1);
                run_store(a, f3, word, rdy, be, wd, ad, we, stalls, ok);
                checks++;
                if (be !== exp_be(f3, a % 4) || wd !== exp_wd(f3, word)
                    || ad !== a - a % 4 || !we || stalls !== rdy + 1
                    || !ok) begin
                    errors++;
                    $display("FAIL rnd_store f3 %0d a %h got %b %h %0d exp %b %h %0d",
                        f3, a, be, wd, stalls, exp_be(f3, a % 4),
                        exp_wd(f3, word), rdy + 1);
                end
            end else begin
                do begin
                    ld = 1'($urandom); st = 1'($urandom);
                    f3 = 3'($urandom); a = $urandom;
                end while (exp_legal(ld, st, f3, a) || !(ld || st));
                @(negedge clk);
                set_nop();
                mr = ld; mw = st; f3_in = f3; alu_in = a;
                bus.dmem_ready = 1;
                #1;
                checks++;
                if ({exc, bus.dmem_req, rw_out, stall} !== 4'b1000) begin
                    errors++;
                    $display("FAIL rnd_illegal r%b w%b f3 %0d a %h got %b exp 1000",
                        ld, st, f3, a, {exc, bus.dmem_req, rw_out, stall});
                end
                bus.dmem_ready = 0;
            end
        end
    endtask

    initial begin
        rst = 1;
        set_nop();
        bus.dmem_ready = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
        test_reset();
        test_nonmem();
        test_sb();
        test_load_format();
        test_illegal();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
